// File: rtl/corner_editor.sv
// corner_editor: holds the four document-corner coordinates feeding the
// perspective-transform datapath. Corners are loaded from the auto-detector
// and can then be nudged one at a time with direction buttons. Holding a
// button auto-repeats after a delay. All coordinates stay inside the frame.
module corner_editor #(
  parameter int X_MAX         = 639,
  parameter int Y_MAX         = 479,
  parameter int REPEAT_DELAY  = 16250000,
  parameter int REPEAT_PERIOD = 1625000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_corners,
  input  logic [43:0] auto_x,
  input  logic [39:0] auto_y,
  input  logic        enable,
  input  logic        button_next,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [43:0] corners_x,
  output logic [39:0] corners_y,
  output logic [1:0]  selected,
  output logic        corners_valid,
  output logic        corners_changed
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);
  localparam logic [10:0]   X_LIM       = 11'(X_MAX);
  localparam logic [9:0]    Y_LIM       = 10'(Y_MAX);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  logic [1:0]    state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          do_step;

  logic [43:0] auto_x_clamped;
  logic [39:0] auto_y_clamped;

  logic        move_right, move_left, move_down, move_up, active;
  logic [5:0]  x_base, y_base;
  logic [10:0] cur_x, step_x;
  logic [9:0]  cur_y, step_y;

  // Opposing buttons cancel each other out.
  assign move_right = btn_right & ~btn_left;
  assign move_left  = btn_left  & ~btn_right;
  assign move_down  = btn_down  & ~btn_up;
  assign move_up    = btn_up    & ~btn_down;
  assign active     = enable & (move_right | move_left | move_down | move_up);

  assign x_base = 6'(selected) * 6'd11;
  assign y_base = 6'(selected) * 6'd10;
  assign cur_x  = corners_x[x_base +: 11];
  assign cur_y  = corners_y[y_base +: 10];

  // Clamp incoming auto-detected corners to the frame.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    auto_x_clamped = auto_x;
    auto_y_clamped = auto_y;
    for (int i = 0; i < 4; i++) begin
      if (auto_x[11*i +: 11] > X_LIM) auto_x_clamped[11*i +: 11] = X_LIM;
      if (auto_y[10*i +: 10] > Y_LIM) auto_y_clamped[10*i +: 10] = Y_LIM;
    end
  end

  // Saturating one-unit step of the selected corner.
  always_comb begin
    step_x = cur_x;
    step_y = cur_y;
    if (move_right && cur_x < X_LIM)        step_x = cur_x + 11'd1;
    else if (move_left && cur_x != 11'd0)   step_x = cur_x - 11'd1;
    if (move_down && cur_y < Y_LIM)         step_y = cur_y + 10'd1;
    else if (move_up && cur_y != 10'd0)     step_y = cur_y - 10'd1;
  end

  // Button repeat timing: first step immediately, then after a delay, then periodically.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    do_step    = 1'b0;
    if (set_corners || !active) begin
      state_next = S_IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          do_step    = 1'b1;
          cnt_next   = '0;
          state_next = S_HOLD;
        end
        S_HOLD: begin
          if (cnt == DELAY_LAST) begin
            do_step    = 1'b1;
            cnt_next   = '0;
            state_next = S_REPEAT;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        S_REPEAT: begin
          if (cnt == PERIOD_LAST) begin
            do_step  = 1'b1;
            cnt_next = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        default: begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Corner storage, selection and repeat-FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the corner registers are reset too; downstream relies on all-zero corners after reset.
      state           <= S_IDLE;
      cnt             <= '0;
      corners_x       <= '0;
      corners_y       <= '0;
      selected        <= 2'd0;
      corners_valid   <= 1'b0;
      corners_changed <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state           <= state_next;
      cnt             <= cnt_next;
      corners_changed <= 1'b0;
      if (set_corners) begin
        corners_x       <= auto_x_clamped;
        corners_y       <= auto_y_clamped;
        selected        <= 2'd0;
        corners_valid   <= 1'b1;
        corners_changed <= 1'b1;
      end else begin
        // A step uses the selection from before any concurrent button_next.
        if (do_step) begin
          corners_x[x_base +: 11] <= step_x;
          corners_y[y_base +: 10] <= step_y;
          corners_changed         <= (step_x != cur_x) || (step_y != cur_y);
        end
        if (enable && button_next) selected <= selected + 2'd1;
      end
    end
  end

endmodule
